// File: rtl/md5core_io.sv
// Core-side block buffer, per-context in-order scheduler and result serializer
// sitting between the engine broadcast bus and the MD5 round datapath.
module md5core_io #(
  parameter int BLK_OP_MSB = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [31:0]           din,
  input  logic [3:0]            wr_addr,
  input  logic [BLK_OP_MSB:0]   blk_op,
  input  logic                  input_ctx,
  input  logic                  input_seq,
  input  logic                  set_input_ready,
  output logic [3:0]            ready,
  output logic                  blk_start,
  output logic                  blk_start_ctx,
  output logic                  blk_start_seq,
  output logic [BLK_OP_MSB:0]   blk_start_op,
  input  logic                  rd_ctx,
  input  logic                  rd_seq,
  input  logic [3:0]            rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  blk_done,
  input  logic                  done_ctx,
  input  logic                  done_seq,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic                  res_ctx,
  input  logic                  res_seq,
  input  logic [127:0]          res_data,
  output logic                  dout_en,
  output logic                  dout_seq_num,
  output logic                  dout_ctx_num,
  output logic [31:0]           dout,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_W1   = 3'd2,
    S_W2   = 3'd3,
    S_W3   = 3'd4
  } ser_state_t;

  logic [31:0]         r_mem [0:63];
  logic [31:0]         r_rd_data;
  logic [3:0]          r_full;
  logic [3:0]          r_ready;
  logic [BLK_OP_MSB:0] r_op [0:3];
  logic [1:0]          r_busy;
  logic [1:0]          r_exp_seq;
  logic                r_rr;
  logic                r_err;
  logic                r_blk_start;
  logic                r_blk_start_ctx;
  logic                r_blk_start_seq;
  logic [BLK_OP_MSB:0] r_blk_start_op;

  ser_state_t          r_state;
  ser_state_t          w_state_nxt;
  logic [127:0]        r_res_data;
  logic                r_res_ready;
  logic                r_dout_en;
  logic                r_dout_seq;
  logic                r_dout_ctx;
  logic [31:0]         r_dout;

  logic [1:0]          w_in_slot;
  logic [1:0]          w_done_slot;
  logic                w_wr_ok;
  logic                w_commit_ok;
  logic [1:0]          w_elig;
  logic                w_start;
  logic                w_start_ctx;
  logic                w_start_seq;
  logic [BLK_OP_MSB:0] w_start_op;
  logic [3:0]          w_full_nxt;
  logic [1:0]          w_busy_nxt;
  logic [1:0]          w_exp_nxt;
  logic                w_rr_nxt;
  logic                w_err_nxt;
  logic                w_load;
  logic                w_res_ready_nxt;
  logic                w_dout_en_nxt;
  logic                w_dout_seq_nxt;
  logic                w_dout_ctx_nxt;
  logic [31:0]         w_dout_nxt;

  assign w_in_slot   = {input_seq, input_ctx};
  assign w_done_slot = {done_seq, done_ctx};
  assign w_wr_ok     = wr_en & ~r_full[w_in_slot];
  assign w_commit_ok = set_input_ready & ~r_full[w_in_slot];

  // A context may start only its next expected sequence slot, and only when idle.
  assign w_elig[0] = ~r_busy[0] & r_full[{r_exp_seq[0], 1'b0}];
  assign w_elig[1] = ~r_busy[1] & r_full[{r_exp_seq[1], 1'b1}];

  // Block storage write port
  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      r_mem[{input_seq, input_ctx, wr_addr}] <= din;
    end
  end

  // Registered datapath read port
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_data <= 32'h0;
    end else begin
      r_rd_data <= r_mem[{rd_seq, rd_ctx, rd_addr}];
    end
  end

  // Scheduler pick, slot bookkeeping and error detection
  always_comb begin
    w_full_nxt  = r_full;
    w_busy_nxt  = r_busy;
    w_exp_nxt   = r_exp_seq;
    w_rr_nxt    = r_rr;
    w_err_nxt   = r_err;
    w_start     = |w_elig;
    w_start_ctx = 1'b0;

    if (w_elig[0] && w_elig[1]) begin
      w_start_ctx = r_rr;
    end else if (w_elig[1]) begin
      w_start_ctx = 1'b1;
    end else begin
      w_start_ctx = 1'b0;
    end
    w_start_seq = r_exp_seq[w_start_ctx];
    w_start_op  = r_op[{w_start_seq, w_start_ctx}];

    if (w_start) begin
      w_busy_nxt[w_start_ctx] = 1'b1;
      w_exp_nxt[w_start_ctx]  = ~r_exp_seq[w_start_ctx];
      w_rr_nxt                = ~r_rr;
    end else begin
      w_rr_nxt = r_rr;
    end

    // busy gates done and start, so they never touch the same context together
    if (blk_done) begin
      if (r_busy[done_ctx]) begin
        w_full_nxt[w_done_slot] = 1'b0;
        w_busy_nxt[done_ctx]    = 1'b0;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else begin
      w_err_nxt = w_err_nxt;
    end

    if (set_input_ready) begin
      if (r_full[w_in_slot]) begin
        w_err_nxt = 1'b1;
      end else begin
        w_full_nxt[w_in_slot] = 1'b1;
      end
    end else begin
      w_err_nxt = w_err_nxt;
    end

    if (wr_en && r_full[w_in_slot]) begin
      w_err_nxt = 1'b1;
    end else begin
      w_err_nxt = w_err_nxt;
    end
  end

  // Slot and context state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_full          <= 4'b0000;
      r_ready         <= 4'b1111;
      r_busy          <= 2'b00;
      r_exp_seq       <= 2'b00;
      r_rr            <= 1'b0;
      r_err           <= 1'b0;
      r_blk_start     <= 1'b0;
      r_blk_start_ctx <= 1'b0;
      r_blk_start_seq <= 1'b0;
      r_blk_start_op  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_op[i] <= '0;
      end
    end else begin
      r_full      <= w_full_nxt;
      r_ready     <= ~w_full_nxt;
      r_busy      <= w_busy_nxt;
      r_exp_seq   <= w_exp_nxt;
      r_rr        <= w_rr_nxt;
      r_err       <= w_err_nxt;
      r_blk_start <= w_start;
      if (w_start) begin
        r_blk_start_ctx <= w_start_ctx;
        r_blk_start_seq <= w_start_seq;
        r_blk_start_op  <= w_start_op;
      end
      if (w_commit_ok) begin
        r_op[w_in_slot] <= blk_op;
      end
    end
  end

  // Serializer next state and next output word
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_dout_en_nxt  = 1'b0;
    w_dout_nxt     = 32'h0;
    w_dout_seq_nxt = 1'b0;
    w_dout_ctx_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_W3: begin
        if (res_valid) begin
          w_state_nxt    = S_W0;
          w_load         = 1'b1;
          w_dout_en_nxt  = 1'b1;
          w_dout_nxt     = res_data[31:0];
          w_dout_seq_nxt = res_seq;
          w_dout_ctx_nxt = res_ctx;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_W0: begin
        w_state_nxt    = S_W1;
        w_dout_en_nxt  = 1'b1;
        w_dout_nxt     = r_res_data[63:32];
        w_dout_seq_nxt = r_dout_seq;
        w_dout_ctx_nxt = r_dout_ctx;
      end
      S_W1: begin
        w_state_nxt    = S_W2;
        w_dout_en_nxt  = 1'b1;
        w_dout_nxt     = r_res_data[95:64];
        w_dout_seq_nxt = r_dout_seq;
        w_dout_ctx_nxt = r_dout_ctx;
      end
      S_W2: begin
        w_state_nxt    = S_W3;
        w_dout_en_nxt  = 1'b1;
        w_dout_nxt     = r_res_data[127:96];
        w_dout_seq_nxt = r_dout_seq;
        w_dout_ctx_nxt = r_dout_ctx;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_res_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_W3);
  end

  // Serializer state and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_res_data  <= 128'h0;
      r_res_ready <= 1'b1;
      r_dout_en   <= 1'b0;
      r_dout      <= 32'h0;
      r_dout_seq  <= 1'b0;
      r_dout_ctx  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_res_ready <= w_res_ready_nxt;
      r_dout_en   <= w_dout_en_nxt;
      r_dout      <= w_dout_nxt;
      r_dout_seq  <= w_dout_seq_nxt;
      r_dout_ctx  <= w_dout_ctx_nxt;
      if (w_load) begin
        r_res_data <= res_data;
      end
    end
  end

  assign ready         = r_ready;
  assign blk_start     = r_blk_start;
  assign blk_start_ctx = r_blk_start_ctx;
  assign blk_start_seq = r_blk_start_seq;
  assign blk_start_op  = r_blk_start_op;
  assign rd_data       = r_rd_data;
  assign res_ready     = r_res_ready;
  assign dout_en       = r_dout_en;
  assign dout          = r_dout;
  assign dout_seq_num  = r_dout_seq;
  assign dout_ctx_num  = r_dout_ctx;
  assign err           = r_err;

endmodule

// File: tb/tb_md5core_io.sv
// Directed bench for md5core_io: buffering, in-order scheduling, round-robin,
// result serialization, protocol errors and asynchronous reset.
module tb_md5core_io;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         wr_en;
  logic [31:0]  din;
  logic [3:0]   wr_addr;
  logic [1:0]   blk_op;
  logic         input_ctx;
  logic         input_seq;
  logic         set_input_ready;
  logic [3:0]   ready;
  logic         blk_start;
  logic         blk_start_ctx;
  logic         blk_start_seq;
  logic [1:0]   blk_start_op;
  logic         rd_ctx;
  logic         rd_seq;
  logic [3:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         blk_done;
  logic         done_ctx;
  logic         done_seq;
  logic         res_valid;
  logic         res_ready;
  logic         res_ctx;
  logic         res_seq;
  logic [127:0] res_data;
  logic         dout_en;
  logic         dout_seq_num;
  logic         dout_ctx_num;
  logic [31:0]  dout;
  logic         err;

  int total = 0;
  int bad   = 0;
  logic [127:0] r1;
  logic [127:0] r2;
  logic [31:0]  exp_word;

  md5core_io #(.BLK_OP_MSB(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .din(din), .wr_addr(wr_addr),
    .blk_op(blk_op), .input_ctx(input_ctx), .input_seq(input_seq),
    .set_input_ready(set_input_ready), .ready(ready), .blk_start(blk_start),
    .blk_start_ctx(blk_start_ctx), .blk_start_seq(blk_start_seq),
    .blk_start_op(blk_start_op), .rd_ctx(rd_ctx), .rd_seq(rd_seq),
    .rd_addr(rd_addr), .rd_data(rd_data), .blk_done(blk_done),
    .done_ctx(done_ctx), .done_seq(done_seq), .res_valid(res_valid),
    .res_ready(res_ready), .res_ctx(res_ctx), .res_seq(res_seq),
    .res_data(res_data), .dout_en(dout_en), .dout_seq_num(dout_seq_num),
    .dout_ctx_num(dout_ctx_num), .dout(dout), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic commit(input logic c, input logic s, input logic [1:0] op);
    set_input_ready = 1'b1;
    input_ctx       = c;
    input_seq       = s;
    blk_op          = op;
    tick();
    set_input_ready = 1'b0;
  endtask

  task automatic chk_start(input string tag, input logic c, input logic s, input logic [1:0] op);
    chk({tag, "_pulse"}, blk_start, 1'b1);
    chk({tag, "_ctx"}, blk_start_ctx, c);
    chk({tag, "_seq"}, blk_start_seq, s);
    chk({tag, "_op"}, blk_start_op, op);
  endtask

  initial begin
    RST_N = 1'b0; wr_en = 1'b0; din = 32'h0; wr_addr = 4'h0; blk_op = 2'd0;
    input_ctx = 1'b0; input_seq = 1'b0; set_input_ready = 1'b0;
    rd_ctx = 1'b0; rd_seq = 1'b0; rd_addr = 4'h0;
    blk_done = 1'b0; done_ctx = 1'b0; done_seq = 1'b0;
    res_valid = 1'b0; res_ctx = 1'b0; res_seq = 1'b0; res_data = 128'h0;
    r1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    r2 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    // reset values
    do_reset();
    chk("rst_ready", ready, 4'b1111);
    chk("rst_start", blk_start, 1'b0);
    chk("rst_res_ready", res_ready, 1'b1);
    chk("rst_dout_en", dout_en, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);

    // fill ctx0/seq0, commit op=2, read back
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; input_ctx = 1'b0; input_seq = 1'b0;
      wr_addr = i[3:0]; din = 32'h1000 + i;
      tick();
    end
    wr_en = 1'b0;
    commit(1'b0, 1'b0, 2'd2);
    chk("c00_ready", ready, 4'b1110);
    chk("c00_nostart_yet", blk_start, 1'b0);
    tick();
    chk_start("c00_start", 1'b0, 1'b0, 2'd2);
    tick();
    chk("c00_pulse_end", blk_start, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_ctx = 1'b0; rd_seq = 1'b0; rd_addr = i[3:0];
      tick();
      chk("rd_word", rd_data, 32'h1000 + i);
    end
    blk_done = 1'b1; done_ctx = 1'b0; done_seq = 1'b0;
    tick();
    blk_done = 1'b0;
    chk("done00_ready", ready, 4'b1111);
    chk("done00_err", err, 1'b0);

    // in-order: exp_seq[0] is now 1; seq0 committed first must wait
    commit(1'b0, 1'b0, 2'd3);
    chk("ooo_ready", ready, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ooo_hold", blk_start, 1'b0);
    end
    commit(1'b0, 1'b1, 2'd1);
    chk("ooo_ready2", ready, 4'b1010);
    chk("ooo_nostart", blk_start, 1'b0);
    tick();
    chk_start("ooo_s1", 1'b0, 1'b1, 2'd1);
    tick();
    chk("ooo_busy_hold1", blk_start, 1'b0);
    tick();
    chk("ooo_busy_hold2", blk_start, 1'b0);
    blk_done = 1'b1; done_ctx = 1'b0; done_seq = 1'b1;
    tick();
    blk_done = 1'b0;
    chk("ooo_done_ready", ready, 4'b1110);
    chk("ooo_done_nostart", blk_start, 1'b0);
    tick();
    chk_start("ooo_s0", 1'b0, 1'b0, 2'd3);
    blk_done = 1'b1; done_ctx = 1'b0; done_seq = 1'b0;
    tick();
    blk_done = 1'b0;
    chk("ooo_final_ready", ready, 4'b1111);

    // write to a full slot: dropped, err set
    wr_en = 1'b1; input_ctx = 1'b1; input_seq = 1'b0; wr_addr = 4'h0; din = 32'hABCD0001;
    tick();
    wr_en = 1'b0;
    commit(1'b1, 1'b0, 2'd3);
    tick();
    chk_start("c10_start", 1'b1, 1'b0, 2'd3);
    chk("wrfull_err_before", err, 1'b0);
    wr_en = 1'b1; input_ctx = 1'b1; input_seq = 1'b0; wr_addr = 4'h0; din = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    chk("wrfull_err", err, 1'b1);
    rd_ctx = 1'b1; rd_seq = 1'b0; rd_addr = 4'h0;
    tick();
    chk("wrfull_keep", rd_data, 32'hABCD0001);
    chk("wrfull_ready", ready, 4'b1101);
    tick();
    chk("wrfull_err_sticky", err, 1'b1);

    // commit to a full slot; reset also aborts the busy block above
    do_reset();
    chk("rst2_err", err, 1'b0);
    chk("rst2_ready", ready, 4'b1111);
    commit(1'b0, 1'b0, 2'd0);
    chk("cfull_err_before", err, 1'b0);
    commit(1'b0, 1'b0, 2'd1);
    chk("cfull_err", err, 1'b1);
    chk("cfull_ready", ready, 4'b1110);

    // done on an idle context
    do_reset();
    blk_done = 1'b1; done_ctx = 1'b1; done_seq = 1'b0;
    tick();
    blk_done = 1'b0;
    chk("idle_done_err", err, 1'b1);
    chk("idle_done_ready", ready, 4'b1111);

    // round-robin: both contexts eligible in the same cycle with rr=0
    do_reset();
    commit(1'b0, 1'b0, 2'd0);
    commit(1'b1, 1'b0, 2'd0);
    tick();
    blk_done = 1'b1; done_ctx = 1'b1; done_seq = 1'b0;
    tick();
    blk_done = 1'b0;
    commit(1'b0, 1'b1, 2'd2);
    chk("rr_hold", blk_start, 1'b0);
    blk_done = 1'b1; done_ctx = 1'b0; done_seq = 1'b0;
    commit(1'b1, 1'b1, 2'd1);
    blk_done = 1'b0;
    chk("rr_ready", ready, 4'b0011);
    chk("rr_nostart", blk_start, 1'b0);
    tick();
    chk_start("rr_first", 1'b0, 1'b1, 2'd2);
    tick();
    chk_start("rr_second", 1'b1, 1'b1, 2'd1);
    tick();
    chk("rr_end", blk_start, 1'b0);

    // back-to-back results: 8 contiguous words
    chk("ser_idle_ready", res_ready, 1'b1);
    res_valid = 1'b1; res_data = r1; res_ctx = 1'b1; res_seq = 1'b1;
    tick();
    res_data = r2; res_ctx = 1'b0; res_seq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_word = (k < 4) ? r1[32*k +: 32] : r2[32*(k-4) +: 32];
      chk("ser_en", dout_en, 1'b1);
      chk("ser_word", dout, exp_word);
      chk("ser_ctx", dout_ctx_num, (k < 4) ? 1'b1 : 1'b0);
      chk("ser_seq", dout_seq_num, (k < 4) ? 1'b1 : 1'b0);
      if (k == 0) chk("ser_w0_ready", res_ready, 1'b0);
      if (k == 3) chk("ser_w3_ready", res_ready, 1'b1);
      if (k == 4) res_valid = 1'b0;
      tick();
    end
    chk("ser_after_en", dout_en, 1'b0);
    chk("ser_after_ready", res_ready, 1'b1);

    // asynchronous reset during W2 with both contexts busy
    res_valid = 1'b1; res_data = r1; res_ctx = 1'b1; res_seq = 1'b0;
    tick();
    res_valid = 1'b0;
    tick();
    tick();
    chk("w2_word", dout, 32'h33333333);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_dout_en", dout_en, 1'b0);
    chk("arst_dout", dout, 32'h0);
    chk("arst_ready", ready, 4'b1111);
    chk("arst_res_ready", res_ready, 1'b1);
    chk("arst_start", blk_start, 1'b0);
    tick();
    RST_N = 1'b1;
    tick();
    tick();
    chk("post_rst_dout_en", dout_en, 1'b0);
    chk("post_rst_ready", ready, 4'b1111);
    commit(1'b0, 1'b0, 2'd1);
    tick();
    chk_start("post_rst_start", 1'b0, 1'b0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md5core_io.md
# md5core_io

Core-side endpoint of the engine→core block-write bus and core→engine result bus. It buffers up to four 16×32-bit input blocks, one slot per {seq, ctx}, and reports per-slot availability on `ready`. It schedules full blocks to the MD5 round datapath in per-context sequence order, and serializes 128-bit results into four 32-bit words on the `dout` bus. One instance sits inside every core, between the engine's `core_*` broadcast signals and the round pipeline.

## Interface
Parameters:
- `BLK_OP_MSB`, default 1: MSB of block-op field, matches the engine's `core_blk_op`.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `wr_en` in 1: this core's bit of `core_wr_en`; write `din` into the current slot.
- `din` in 32: block word.
- `wr_addr` in 4: word index 0–15 within the block.
- `blk_op` in BLK_OP_MSB+1: block op, latched on `set_input_ready`.
- `input_ctx` in 1: target context of the current write or commit.
- `input_seq` in 1: target sequence slot of the current write or commit.
- `set_input_ready` in 1: commit slot {input_seq, input_ctx} as full.
- `ready` out 4: `ready[{seq,ctx}]`=1 means the slot is free for engine writes.
- `blk_start` out 1: one-cycle pulse; a full block is handed to the datapath.
- `blk_start_ctx` out 1: context of the block handed over by `blk_start`.
- `blk_start_seq` out 1: sequence slot of the block handed over by `blk_start`.
- `blk_start_op` out BLK_OP_MSB+1: latched op of the started slot.
- `rd_ctx` in 1: context of the datapath read.
- `rd_seq` in 1: sequence slot of the datapath read.
- `rd_addr` in 4: word index of the datapath read.
- `rd_data` out 32: word at {rd_seq, rd_ctx, rd_addr}, one-cycle registered latency.
- `blk_done` in 1: datapath finished slot {done_seq, done_ctx}; the slot is released.
- `done_ctx` in 1: context of the finished slot.
- `done_seq` in 1: sequence slot of the finished slot.
- `res_valid` in 1: result handshake, valid side.
- `res_ready` out 1: result handshake, ready side.
- `res_ctx` in 1: context of the offered result.
- `res_seq` in 1: sequence number of the offered result.
- `res_data` in 128: offered result.
- `dout_en` out 1: word strobe; maps to `core_dout_en`.
- `dout_seq_num` out 1: maps to `core_dout_seq_num`.
- `dout_ctx_num` out 1: maps to `core_dout_ctx_num`.
- `dout` out 32: result word.
- `err` out 1: sticky protocol error.

## Operation
- Storage: 64×32 RAM, address {seq, ctx, word}. No reset of contents.
- Per-slot state: `full`, `op`. `ready[i] = ~full[i]`, registered.
- Per-ctx state: `busy[c]` and `exp_seq[c]`, the next seq to start.
- Write: `wr_en` stores `din` at {input_seq, input_ctx, wr_addr}. If that slot is full, the write is dropped and `err` is set.
- Commit: `set_input_ready` sets `full` and latches `op` for the slot. Commit to an already-full slot sets `err`; state is unchanged.
- Scheduler, evaluated each cycle from registered state:
  - A ctx c is eligible when `!busy[c] && full[{exp_seq[c], c}]`.
  - If both contexts are eligible, a 1-bit round-robin pointer picks one; the pointer flips after each start.
  - On a start, register `blk_start`=1 with ctx, seq and op; set `busy[c]`; toggle `exp_seq[c]`.
- Release: `blk_done` clears `full[{done_seq,done_ctx}]` and `busy[done_ctx]`. `blk_done` for a ctx that is not busy sets `err` and is otherwise ignored.
- Output serializer, states IDLE, W0, W1, W2, W3:
  - IDLE: `res_ready`=1. On `res_valid` go to W0, latching data, ctx and seq.
  - Wk emits `dout` = `res_data[32k+31:32k]` with `dout_en`=1 and the latched seq/ctx.
  - `res_ready`=1 in IDLE and W3. Acceptance in W3 goes straight to W0 (back-to-back, no bubble); otherwise W3 goes to IDLE.

## Timing
- Reset values: `ready`=4'b1111, `blk_start`=0, `blk_start_ctx/seq/op`=0, `rd_data`=0, `res_ready`=1, `dout_en`=0, `dout*`=0, `err`=0. Also `busy`=0, `exp_seq`=0, rr=0, serializer IDLE.
- Reset mid-operation aborts any block in flight and any result in flight; all slots become free.
- `wr_en` at edge t: the word is readable with `rd_addr` presented in cycle t+1 and appears on `rd_data` in cycle t+2.
- `set_input_ready` at edge t: `ready` bit is low from t+1. The earliest `blk_start` is high in cycle t+2 if the ctx is idle.
- `blk_done` at edge t: `ready` bit is high from t+1. A new start for that ctx comes no earlier than t+2; `busy` is read from the register, so start and done for the same ctx never coincide.
- `blk_done` and a commit to the other seq of the same ctx may occur in the same cycle; both take effect.
- Result accepted at edge t: `dout_en` is high in cycles t+1…t+4. Sustained throughput is one result per 4 cycles.

## Test plan
- Reset, then write words 0–15 = 0x1000+i to ctx0/seq0 and commit with op=2 → `ready`=4'b1110; `blk_start` pulse with ctx0, seq0, op2; reads of words 0–15 return 0x1000+i.
- Commit ctx0/seq1 before ctx0/seq0 → no `blk_start` until seq0 is committed. Then seq0 starts. Seq1 starts only after `blk_done`(ctx0, seq0).
- Both contexts full and idle in the same cycle → starts alternate ctx0 then ctx1 (rr=0), each a single one-cycle pulse.
- Send two results back-to-back, 0x44…/0x33…/0x22…/0x11… words with ctx1/seq1, then a second result → 8 consecutive `dout_en` cycles, low word first, correct ctx/seq tags, no gap.
- Write to a full slot, commit a full slot, `blk_done` on an idle ctx → `err` goes high and stays high; slot contents and `ready` unchanged.
- Assert `RST_N` low during W2 and while a block is busy → outputs reach reset values asynchronously; after release, `ready`=4'b1111 and no `dout_en`.
